// File: rtl/control_sequencer.sv
// Six-step fetch/execute control sequencer for the mini computer.
// Each step lasts PH_CYC clocks; enables cover phases 1..PH_CYC-1, load strobes pulse at PH_CYC-2.
module control_sequencer #(
  parameter int  NREG   = 4,
  parameter int  PH_CYC = 4,
  localparam int RSEL_W = $clog2(NREG),
  localparam int IR_W   = 4 + 2*RSEL_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IR_W-1:0] i_ir,
  input  logic [3:0]      i_alu_flags,
  output logic            o_bus1,
  output logic            o_iar_en,
  output logic            o_ram_en,
  output logic            o_acc_en,
  output logic            o_ir_set,
  output logic            o_mar_set,
  output logic            o_iar_set,
  output logic            o_acc_set,
  output logic            o_ram_set,
  output logic            o_tmp_set,
  output logic [NREG-1:0] o_reg_en,
  output logic [NREG-1:0] o_reg_set,
  output logic [2:0]      o_alu_op,
  output logic [3:0]      o_flags,
  output logic [5:0]      o_step,
  output logic            o_halted
);

  localparam int PH_W = $clog2(PH_CYC);
  localparam logic [PH_W-1:0] PH_SET  = PH_W'(PH_CYC - 2);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PH_CYC - 1);

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_DATA  = 3'd2;
  localparam logic [2:0] OP_JMPR  = 3'd3;
  localparam logic [2:0] OP_JMP   = 3'd4;
  localparam logic [2:0] OP_JCAF  = 3'd5;
  localparam logic [2:0] OP_CLF   = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;
  localparam logic [2:0] ALU_CMP  = 3'd7;

  logic [5:0]      r_step;
  logic [PH_W-1:0] r_phase;
  logic [3:0]      r_flags;
  logic            r_halted;
  logic            r_live;

  logic              w_is_alu;
  logic [2:0]        w_op;
  logic [RSEL_W-1:0] w_rb;
  logic [RSEL_W-1:0] w_ra;
  logic              w_live;
  logic              w_en_win;
  logic              w_set_win;
  logic              w_flag_load;
  logic              w_flag_clr;
  logic              w_halt_now;

  logic              w_req_bus1, w_req_iar_en, w_req_ram_en, w_req_acc_en;
  logic              w_req_ir_set, w_req_mar_set, w_req_iar_set;
  logic              w_req_acc_set, w_req_ram_set, w_req_tmp_set;
  logic              w_req_reg_en, w_req_reg_set;
  logic [RSEL_W-1:0] w_reg_en_sel, w_reg_set_sel;
  logic [2:0]        w_req_alu_op;

  assign w_is_alu = i_ir[IR_W-1];
  assign w_op     = i_ir[IR_W-2:IR_W-4];
  assign w_rb     = i_ir[2*RSEL_W-1:RSEL_W];
  assign w_ra     = i_ir[RSEL_W-1:0];

  // r_live keeps bus1/alu_op quiet in the very first phase after reset.
  assign w_live     = r_live & ~r_halted;
  assign w_en_win   = w_live && (r_phase != '0);
  assign w_set_win  = w_live && (r_phase == PH_SET);
  assign w_flag_load = w_set_win && (r_step == S5) && w_is_alu;
  assign w_flag_clr  = w_set_win && (r_step == S4) && !w_is_alu && (w_op == OP_CLF);
  assign w_halt_now  = (r_step == S4) && !w_is_alu && (w_op == OP_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step   <= S1;
      r_phase  <= '0;
      r_flags  <= 4'd0;
      r_halted <= 1'b0;
      r_live   <= 1'b0;
    end else if (!r_halted) begin
      r_live <= 1'b1;
      if (r_phase == PH_LAST) begin
        if (w_halt_now) begin
          r_halted <= 1'b1;
        end else begin
          r_phase <= '0;
          r_step  <= {r_step[4:0], r_step[5]};
        end
      end else begin
        r_phase <= r_phase + 1'b1;
      end
      if (w_flag_load)     r_flags <= i_alu_flags;
      else if (w_flag_clr) r_flags <= 4'd0;
    end
  end

  always_comb begin
    w_req_bus1    = 1'b0; w_req_iar_en  = 1'b0; w_req_ram_en  = 1'b0; w_req_acc_en = 1'b0;
    w_req_ir_set  = 1'b0; w_req_mar_set = 1'b0; w_req_iar_set = 1'b0;
    w_req_acc_set = 1'b0; w_req_ram_set = 1'b0; w_req_tmp_set = 1'b0;
    w_req_reg_en  = 1'b0; w_req_reg_set = 1'b0;
    w_reg_en_sel  = w_ra; w_reg_set_sel = w_rb;
    w_req_alu_op  = 3'd0;
    case (r_step)
      S1: begin w_req_bus1 = 1'b1; w_req_iar_en = 1'b1; w_req_mar_set = 1'b1; w_req_acc_set = 1'b1; end
      S2: begin w_req_ram_en = 1'b1; w_req_ir_set = 1'b1; end
      S3: begin w_req_acc_en = 1'b1; w_req_iar_set = 1'b1; end
      S4: begin
        if (w_is_alu) begin
          w_req_reg_en = 1'b1; w_reg_en_sel = w_rb; w_req_tmp_set = 1'b1;
        end else begin
          case (w_op)
            OP_LOAD, OP_STORE: begin w_req_reg_en = 1'b1; w_req_mar_set = 1'b1; end
            OP_DATA, OP_JCAF: begin
              w_req_bus1 = 1'b1; w_req_iar_en = 1'b1; w_req_mar_set = 1'b1; w_req_acc_set = 1'b1;
            end
            OP_JMPR: begin w_req_reg_en = 1'b1; w_reg_en_sel = w_rb; w_req_iar_set = 1'b1; end
            OP_JMP:  begin w_req_iar_en = 1'b1; w_req_mar_set = 1'b1; end
            default: ;
          endcase
        end
      end
      S5: begin
        if (w_is_alu) begin
          w_req_reg_en = 1'b1; w_req_alu_op = w_op; w_req_acc_set = 1'b1;
        end else begin
          case (w_op)
            OP_LOAD, OP_DATA: begin w_req_ram_en = 1'b1; w_req_reg_set = 1'b1; end
            OP_STORE: begin w_req_reg_en = 1'b1; w_reg_en_sel = w_rb; w_req_ram_set = 1'b1; end
            OP_JMP:   begin w_req_ram_en = 1'b1; w_req_iar_set = 1'b1; end
            OP_JCAF:  begin w_req_acc_en = 1'b1; w_req_iar_set = 1'b1; end
            default: ;
          endcase
        end
      end
      S6: begin
        if (w_is_alu) begin
          if (w_op != ALU_CMP) begin w_req_acc_en = 1'b1; w_req_reg_set = 1'b1; end
        end else if (w_op == OP_DATA) begin
          w_req_acc_en = 1'b1; w_req_iar_set = 1'b1;
        end else if ((w_op == OP_JCAF) && |(i_ir[3:0] & r_flags)) begin
          w_req_ram_en = 1'b1; w_req_iar_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_bus1    = w_live & w_req_bus1;
  assign o_iar_en  = w_en_win & w_req_iar_en;
  assign o_ram_en  = w_en_win & w_req_ram_en;
  assign o_acc_en  = w_en_win & w_req_acc_en;
  assign o_ir_set  = w_set_win & w_req_ir_set;
  assign o_mar_set = w_set_win & w_req_mar_set;
  assign o_iar_set = w_set_win & w_req_iar_set;
  assign o_acc_set = w_set_win & w_req_acc_set;
  assign o_ram_set = w_set_win & w_req_ram_set;
  assign o_tmp_set = w_set_win & w_req_tmp_set;
  assign o_alu_op  = w_live ? w_req_alu_op : 3'd0;
  assign o_flags   = r_flags;
  assign o_step    = r_step;
  assign o_halted  = r_halted;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      assign o_reg_en[gi]  = w_en_win  & w_req_reg_en  & (w_reg_en_sel  == RSEL_W'(gi));
      assign o_reg_set[gi] = w_set_win & w_req_reg_set & (w_reg_set_sel == RSEL_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer: a timeline model predicts every output each clock.
module tb_control_sequencer;
  localparam int PH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] ir;
  logic [3:0] alu_flags;
  logic       bus1, iar_en, ram_en, acc_en;
  logic       ir_set, mar_set, iar_set, acc_set, ram_set, tmp_set;
  logic [3:0] reg_en, reg_set;
  logic [2:0] alu_op;
  logic [3:0] flags;
  logic [5:0] step;
  logic       halted;

  control_sequencer #(.NREG(4), .PH_CYC(PH)) dut (
    .clk(clk), .rst_n(rst_n), .i_ir(ir), .i_alu_flags(alu_flags),
    .o_bus1(bus1), .o_iar_en(iar_en), .o_ram_en(ram_en), .o_acc_en(acc_en),
    .o_ir_set(ir_set), .o_mar_set(mar_set), .o_iar_set(iar_set), .o_acc_set(acc_set),
    .o_ram_set(ram_set), .o_tmp_set(tmp_set), .o_reg_en(reg_en), .o_reg_set(reg_set),
    .o_alu_op(alu_op), .o_flags(flags), .o_step(step), .o_halted(halted)
  );

  logic [31:0] dut_vec;
  assign dut_vec = {bus1, iar_en, ram_en, acc_en, ir_set, mar_set, iar_set, acc_set,
                    ram_set, tmp_set, reg_en, reg_set, alu_op, flags, step, halted};

  localparam logic [31:0] RESET_VEC = 32'h0000_0002;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sb_q[$];

  // Model state: clocks since reset (frozen once halted), latched flags, halt status.
  int         t;
  logic [3:0] m_flags;
  bit         m_halted;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs from the instruction's step table and the phase windows.
  function automatic logic [31:0] model_out(int tt, bit hlt, logic [7:0] v, logic [3:0] fl);
    int s, ph, e_reg, s_reg;
    bit live, en, st;
    bit b1, e_iar, e_ram, e_acc, s_ir, s_mar, s_iar, s_acc, s_ram, s_tmp;
    logic [2:0] aop, op;
    logic [3:0] ren, rset;
    logic [5:0] stp;
    s = (tt / PH) % 6;
    ph = tt % PH;
    live = (tt != 0) && !hlt;
    en = live && (ph >= 1);
    st = live && (ph == PH - 2);
    b1 = 0; e_iar = 0; e_ram = 0; e_acc = 0; s_ir = 0; s_mar = 0; s_iar = 0;
    s_acc = 0; s_ram = 0; s_tmp = 0; e_reg = -1; s_reg = -1; aop = 3'd0;
    op = v[6:4];
    case (s)
      0: begin b1 = 1; e_iar = 1; s_mar = 1; s_acc = 1; end
      1: begin e_ram = 1; s_ir = 1; end
      2: begin e_acc = 1; s_iar = 1; end
      default: begin
        if (v[7]) begin
          if (s == 3) begin e_reg = int'(v[3:2]); s_tmp = 1; end
          else if (s == 4) begin e_reg = int'(v[1:0]); aop = op; s_acc = 1; end
          else if (op != 3'd7) begin e_acc = 1; s_reg = int'(v[3:2]); end
        end else begin
          case (op)
            3'd0: if (s == 3) begin e_reg = int'(v[1:0]); s_mar = 1; end
                  else if (s == 4) begin e_ram = 1; s_reg = int'(v[3:2]); end
            3'd1: if (s == 3) begin e_reg = int'(v[1:0]); s_mar = 1; end
                  else if (s == 4) begin e_reg = int'(v[3:2]); s_ram = 1; end
            3'd2: if (s == 3) begin b1 = 1; e_iar = 1; s_mar = 1; s_acc = 1; end
                  else if (s == 4) begin e_ram = 1; s_reg = int'(v[3:2]); end
                  else begin e_acc = 1; s_iar = 1; end
            3'd3: if (s == 3) begin e_reg = int'(v[3:2]); s_iar = 1; end
            3'd4: if (s == 3) begin e_iar = 1; s_mar = 1; end
                  else if (s == 4) begin e_ram = 1; s_iar = 1; end
            3'd5: if (s == 3) begin b1 = 1; e_iar = 1; s_mar = 1; s_acc = 1; end
                  else if (s == 4) begin e_acc = 1; s_iar = 1; end
                  else if ((v[3:0] & fl) != 4'd0) begin e_ram = 1; s_iar = 1; end
            default: ;
          endcase
        end
      end
    endcase
    ren  = (en && e_reg >= 0) ? 4'(1 << e_reg) : 4'd0;
    rset = (st && s_reg >= 0) ? 4'(1 << s_reg) : 4'd0;
    stp  = 6'(1 << s);
    return {b1 & live, e_iar & en, e_ram & en, e_acc & en, s_ir & st, s_mar & st,
            s_iar & st, s_acc & st, s_ram & st, s_tmp & st, ren, rset,
            live ? aop : 3'd0, fl, stp, hlt};
  endfunction

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end else begin
      $display("ok   %s val=%h", name, act);
    end
  endtask

  // One clock: queue the prediction for the present state, then advance the model.
  task automatic tick(input int af);
    int s, ph;
    alu_flags = (af < 0) ? 4'($urandom) : 4'(af);
    sb_q.push_back({32'(t), model_out(t, m_halted, ir, m_flags)});
    if (!m_halted) begin
      s = (t / PH) % 6;
      ph = t % PH;
      if (ir[7] && s == 4 && ph == PH - 2) m_flags = alu_flags;
      else if (!ir[7] && ir[6:4] == 3'd6 && s == 3 && ph == PH - 2) m_flags = 4'd0;
      if (!ir[7] && ir[6:4] == 3'd7 && s == 3 && ph == PH - 1) m_halted = 1;
      else t++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [7:0] v, input int af);
    ir = v;
    repeat (6 * PH) tick(af);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_now("rst_assert", dut_vec, RESET_VEC);
    repeat (3) @(posedge clk);
    #1;
    check_now("rst_hold", dut_vec, RESET_VEC);
    rst_n = 1'b1;
    t = 0;
    m_flags = 4'd0;
    m_halted = 0;
  endtask

  // Monitor: one comparison per clock against the oldest queued prediction.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (dut_vec !== e[31:0]) begin
          errors++;
          $display("FAIL seq t=%0d act=%h exp=%h ir=%b", e[63:32], dut_vec, e[31:0], ir);
        end else begin
          $display("ok   seq t=%0d val=%h", e[63:32], dut_vec);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1;
    ir = 8'd0;
    alu_flags = 4'd0;
    #2;
    do_reset();
    run_instr(8'b1000_0110, 4'b1000);   // ADD R1 <- R2 + R1
    run_instr(8'b1111_0110, 4'b0011);   // CMP: no writeback
    run_instr(8'b1000_0110, 4'b1000);   // flags = 1000
    run_instr(8'b0101_1000, -1);        // JCAF taken
    run_instr(8'b0110_0000, -1);        // CLF
    run_instr(8'b1001_0101, 4'b0100);   // flags = 0100
    run_instr(8'b0101_1000, -1);        // JCAF not taken
    for (int k = 0; k < 40; k++) begin
      logic [7:0] v;
      v = 8'($urandom);
      if (!v[7] && v[6:4] == 3'd7) v[6:4] = 3'($urandom_range(0, 6));
      run_instr(v, -1);
    end

    // Reset in S5 phase 2 of LOAD R2 <- [R1]
    ir = 8'b0000_1001;
    repeat (4 * PH + 2) tick(-1);
    check_now("load_s5_regset", {28'd0, reg_set}, 32'h4);
    rst_n = 1'b0;
    #1;
    check_now("rst_async_regset", {28'd0, reg_set}, 32'h0);
    check_now("rst_async_all", dut_vec, RESET_VEC);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    t = 0;
    m_flags = 4'd0;
    m_halted = 0;
    run_instr(8'b0000_1001, -1);

    run_instr(8'b0111_0000, -1);        // HALT
    repeat (100) tick(-1);
    do_reset();
    run_instr(8'b1010_0111, -1);

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d exp=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
